data_path: RTL and testbench

DATA_PATH -- requirements
Module: data_path

---
 rtl/data_path.sv | 162 ++++++++++++++++
 tb/tb_data_path.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/data_path.sv
// data_path: display timing generator fed by a word FIFO.
// Pixels are pushed while CSDisplay is high; the px/ln raster counters pop one
// word per active pixel and drive registered PixOut/DE/HBlank/VBlank/FrameStart.
// Optional feature macro: DP_FRAME_COUNT_EN enables the FrameCount counter;
// when undefined FrameCount is tied to zero.
module data_path #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] WData,
  input  logic        CSDisplay,
  input  logic [9:0]  AIPOut_PD,
  input  logic [9:0]  HBOut_PD,
  input  logic [9:0]  AILOut_PD,
  input  logic [9:0]  VBOut_PD,
  output logic [23:0] PixOut,
  output logic        DE,
  output logic        HBlank,
  output logic        VBlank,
  output logic        FrameStart,
  output logic        Full,
  output logic        Underflow,
  output logic [15:0] FrameCount
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [9:0] aip;
    logic [9:0] hb;
    logic [9:0] ail;
    logic [9:0] vb;
  } timing_cfg_t;

  // ---------------------------------------------------------------------------
  // Timing configuration
  // ---------------------------------------------------------------------------
  timing_cfg_t cfg_in, cfg_sh, cfg;
  logic [10:0] px, ln;
  logic        at_origin, load_cfg;
  logic [10:0] line_len, frame_len, last_px, last_ln;
  logic        px_wrap, ln_wrap, active;

  assign cfg_in    = {AIPOut_PD, HBOut_PD, AILOut_PD, VBOut_PD};
  assign at_origin = (px == 11'd0) && (ln == 11'd0);
  assign load_cfg  = at_origin && CSDisplay;

  // A new frame starts with the live inputs so that the (0,0) pixel itself
  // already obeys the new geometry; the rest of the frame uses the shadow.
  assign cfg = load_cfg ? cfg_in : cfg_sh;

  assign line_len  = {1'b0, cfg.aip} + {1'b0, cfg.hb};
  assign frame_len = {1'b0, cfg.ail} + {1'b0, cfg.vb};
  // Zero-length lines/frames degenerate to a single position.
  assign last_px   = (line_len  == 11'd0) ? 11'd0 : line_len  - 11'd1;
  assign last_ln   = (frame_len == 11'd0) ? 11'd0 : frame_len - 11'd1;
  assign px_wrap   = (px >= last_px);
  assign ln_wrap   = (ln >= last_ln);
  assign active    = CSDisplay && (px < {1'b0, cfg.aip}) && (ln < {1'b0, cfg.ail});

  // Shadow geometry: captured throughout reset and at every frame origin
  always_ff @(posedge clk) begin
    if (!reset || load_cfg) cfg_sh <= cfg_in;
  end

  // Raster counters, advance only while the display is selected
  always_ff @(posedge clk) begin
    if (!reset) begin
      px <= '0;
      ln <= '0;
    end else if (CSDisplay) begin
      if (px_wrap) begin
        px <= '0;
        ln <= ln_wrap ? 11'd0 : ln + 11'd1;
      end else begin
        px <= px + 11'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          fifo_empty, push, pop;
  logic [23:0]   rd_data;
  logic          unused_hi;

  // Upper byte of the source word carries no pixel data.
  assign unused_hi = ^WData[31:24];

  assign fifo_empty = (count == '0);
  // Full is the registered flag, so a pop in the same cycle cannot make room
  // for this cycle's push.
  assign push      = CSDisplay && !Full;
  assign pop       = active && !fifo_empty;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign rd_data   = mem[rd_ptr];

  // FIFO storage; contents need no reset, the pointers define validity
  always_ff @(posedge clk) begin
    if (reset && push) mem[wr_ptr] <= WData[23:0];
  end

  // FIFO pointers, occupancy and Full flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      Full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      Full  <= (count_nxt == DEPTH_C);
    end
  end

  // ---------------------------------------------------------------------------
  // Registered video outputs
  // ---------------------------------------------------------------------------
  // Outputs lag the counter state by one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      PixOut     <= '0;
      DE         <= 1'b0;
      HBlank     <= 1'b0;
      VBlank     <= 1'b0;
      FrameStart <= 1'b0;
      Underflow  <= 1'b0;
    end else begin
      DE         <= active;
      HBlank     <= CSDisplay && (px >= {1'b0, cfg.aip});
      VBlank     <= CSDisplay && (ln >= {1'b0, cfg.ail});
      FrameStart <= load_cfg;
      // An underflowing active pixel still shows DE but blanks the data.
      PixOut     <= pop ? rd_data : 24'd0;
      Underflow  <= Underflow | (active && fifo_empty);
    end
  end

`ifdef DP_FRAME_COUNT_EN
  logic [15:0] frame_cnt;

  // Completed frames: counted on the wrap from the last position to (0,0)
  always_ff @(posedge clk) begin
    if (!reset)                             frame_cnt <= '0;
    else if (CSDisplay && px_wrap && ln_wrap) frame_cnt <= frame_cnt + 16'd1;
  end

  assign FrameCount = frame_cnt;
`else
  assign FrameCount = 16'd0;
`endif

endmodule

// File: tb/tb_data_path.sv
// Directed testbench for data_path: reset, raster/pixel sequencing, FIFO full
// and drop, underflow, mid-frame geometry change, display hold, frame count.
module tb_data_path;

`ifdef DP_FRAME_COUNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] WData;
  logic        CSDisplay;
  logic [9:0]  aip, hb, ail, vb;
  logic [23:0] PixOut;
  logic        DE, HBlank, VBlank, FrameStart, Full, Underflow;
  logic [15:0] FrameCount;

  int errors = 0;
  int checks = 0;
  int k = 0;
  logic [11:0] de_bits;

  always #5 clk = ~clk;

  data_path #(.FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .WData(WData), .CSDisplay(CSDisplay),
    .AIPOut_PD(aip), .HBOut_PD(hb), .AILOut_PD(ail), .VBOut_PD(vb),
    .PixOut(PixOut), .DE(DE), .HBlank(HBlank), .VBlank(VBlank),
    .FrameStart(FrameStart), .Full(Full), .Underflow(Underflow),
    .FrameCount(FrameCount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  // Two reset edges with the given geometry; k counts edges after release.
  task automatic do_reset(input logic [9:0] a, input logic [9:0] h,
                          input logic [9:0] l, input logic [9:0] v);
    reset = 1'b0; CSDisplay = 1'b0; WData = '0;
    aip = a; hb = h; ail = l; vb = v;
    tick(); tick();
    reset = 1'b1;
    k = 0;
  endtask

  initial begin
    // ---- reset with random inputs ----
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      WData = $urandom; CSDisplay = 1'($urandom_range(0, 1));
      aip = 10'($urandom); hb = 10'($urandom); ail = 10'($urandom); vb = 10'($urandom);
      tick();
    end
    chk("rst_pix",   PixOut, 0);
    chk("rst_flags", {DE, HBlank, VBlank, FrameStart, Full, Underflow}, 0);
    chk("rst_fc",    FrameCount, 0);

    // ---- 4/2/2/1 raster, words preloaded during two AIL=0 lines ----
    do_reset(10'd4, 10'd2, 10'd0, 10'd1);
    CSDisplay = 1'b1;
    de_bits = '0;
    for (int i = 0; i < 31; i++) begin
      if (k == 12) ail = 10'd2;
      WData = k + 1;
      tick();
      if (k >= 13 && k <= 24) de_bits = {de_bits[10:0], DE};
      case (k)
        1:  begin chk("a_fs_e1", FrameStart, 1); chk("a_vb_e1", VBlank, 1); chk("a_de_e1", DE, 0); end
        13: begin chk("a_fs_e13", FrameStart, 1); chk("a_de_e13", DE, 1); chk("a_pix_e13", PixOut, 1); end
        14: begin chk("a_fs_e14", FrameStart, 0); chk("a_pix_e14", PixOut, 2); end
        16: chk("a_pix_e16", PixOut, 4);
        17: begin chk("a_de_e17", DE, 0); chk("a_hb_e17", HBlank, 1); chk("a_pix_e17", PixOut, 0); end
        19: chk("a_pix_e19", PixOut, 5);
        22: chk("a_pix_e22", PixOut, 8);
        25: begin chk("a_vb_e25", VBlank, 1); chk("a_de_e25", DE, 0); chk("a_hb_e25", HBlank, 0); end
        31: begin chk("a_fs_e31", FrameStart, 1); chk("a_pix_e31", PixOut, 9); chk("a_uf_e31", Underflow, 0); end
        default: ;
      endcase
    end
    chk("a_de_pattern", de_bits, 12'b111100111100);

    // ---- FIFO fill with no active pixels, then drain to find dropped words ----
    do_reset(10'd4, 10'd2, 10'd0, 10'd1);
    CSDisplay = 1'b1;
    for (int i = 0; i < 61; i++) begin
      if (k == 24) ail = 10'd2;
      WData = k + 1;
      tick();
      case (k)
        15: chk("b_full_e15", Full, 0);
        16: chk("b_full_e16", Full, 1);
        20: chk("b_full_e20", Full, 1);
        25: chk("b_pix_e25", PixOut, 1);
        52: chk("b_pix_e52", PixOut, 16);
        61: begin chk("b_pix_e61", PixOut, 26); chk("b_uf_e61", Underflow, 0); end
        default: ;
      endcase
    end

    // ---- underflow, masking of WData[31:24], mid-frame reset ----
    do_reset(10'd4, 10'd2, 10'd2, 10'd1);
    CSDisplay = 1'b1;
    WData = 32'hFF12_3456;
    tick();
    chk("c_de_e1", DE, 1);
    chk("c_pix_e1", PixOut, 0);
    chk("c_uf_e1", Underflow, 1);
    WData = 32'hAB00_0001;
    tick();
    chk("c_pix_e2", PixOut, 32'h12_3456);
    CSDisplay = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("c_uf_sticky", Underflow, 1);
    reset = 1'b0;
    tick();
    chk("c_rst_flags", {DE, HBlank, VBlank, FrameStart, Full, Underflow}, 0);
    chk("c_rst_pix", PixOut, 0);
    reset = 1'b1; CSDisplay = 1'b1; WData = 32'h0000_0077;
    tick();
    chk("c_restart_fs", FrameStart, 1);
    chk("c_restart_pix", PixOut, 0);

    // ---- AIP 4->2 mid-frame, then CSDisplay low for 3 cycles ----
    do_reset(10'd4, 10'd2, 10'd2, 10'd1);
    for (int i = 0; i < 30; i++) begin
      if (k == 2) aip = 10'd2;
      CSDisplay = (k >= 24 && k < 27) ? 1'b0 : 1'b1;
      WData = k + 1;
      tick();
      case (k)
        3:  begin chk("d_hb_e3", HBlank, 0); chk("d_de_e3", DE, 1); end
        5:  chk("d_hb_e5", HBlank, 1);
        7:  begin chk("d_de_e7", DE, 1); chk("d_hb_e7", HBlank, 0); end
        19: begin chk("d_fs_e19", FrameStart, 1); chk("d_de_e19", DE, 1); end
        21: begin chk("d_hb_e21", HBlank, 1); chk("d_de_e21", DE, 0); end
        23: begin chk("d_de_e23", DE, 1); chk("d_hb_e23", HBlank, 0); end
        25: chk("d_de_e25", DE, 0);
        27: chk("d_hold_e27", {DE, HBlank, VBlank}, 0);
        28: begin chk("d_hb_e28", HBlank, 1); chk("d_vb_e28", VBlank, 0); end
        30: chk("d_vb_e30", VBlank, 1);
        default: ;
      endcase
    end

    // ---- zero-size geometry degenerates to one position ----
    do_reset(10'd0, 10'd0, 10'd0, 10'd0);
    CSDisplay = 1'b1;
    tick();
    chk("e_fs_e1", FrameStart, 1);
    tick();
    chk("e_fs_e2", FrameStart, 1);
    chk("e_de_e2", DE, 0);

    // ---- frame counter over 3 frames of 2x2 ----
    do_reset(10'd1, 10'd1, 10'd1, 10'd1);
    CSDisplay = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (k == 11) chk("f_fc_e11", FrameCount, FC_EN ? 2 : 0);
    end
    chk("f_fc_e12", FrameCount, FC_EN ? 3 : 0);
    reset = 1'b0;
    tick();
    chk("f_fc_rst", FrameCount, 0);
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
